// File: rtl/jzjpcc_pkg.sv
// jzjpcc_pkg: shared types and default constants for the memory arbiter slice.
package jzjpcc_pkg;

   typedef enum logic [1:0] {ARB_CORE, ARB_DRAIN, ARB_LOADER, ARB_RESUME} arbState_t;

   localparam int ARB_RAM_A_WIDTH        = 12;
   localparam int ARB_DRAIN_CYCLES       = 4;
   localparam int ARB_RESET_PULSE_CYCLES = 2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/jzjpcc_down_counter.sv
// jzjpcc_down_counter: loadable down counter that saturates at zero and flags it.
module jzjpcc_down_counter #(
   parameter int W = 3
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = load ? load_val : (dec && count_q != '0) ? count_q - 1'b1 : count_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/jzjpcc_mem_arbiter.sv
// jzjpcc_mem_arbiter: shares the backend data port between the core and a loader,
// halting and draining the core before the loader owns the port.
module jzjpcc_mem_arbiter
   import jzjpcc_pkg::*;
#(
   parameter int RAM_A_WIDTH        = ARB_RAM_A_WIDTH,
   parameter int DRAIN_CYCLES       = ARB_DRAIN_CYCLES,
   parameter int RESET_PULSE_CYCLES = ARB_RESET_PULSE_CYCLES
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [RAM_A_WIDTH-1:0] coreAddr,
   input  logic [31:0]            coreWriteData,
   input  logic [3:0]             coreByteMask,
   input  logic                   coreWriteEnable,
   input  logic                   ldrValid,
   output logic                   ldrReady,
   input  logic                   ldrWrite,
   input  logic [RAM_A_WIDTH-1:0] ldrAddr,
   input  logic [31:0]            ldrWriteData,
   output logic [31:0]            ldrReadData,
   output logic                   ldrReadValid,
   input  logic                   ldrRelease,
   input  logic                   ldrResetCore,
   output logic [RAM_A_WIDTH-1:0] memAddr,
   output logic [31:0]            memWriteData,
   output logic [3:0]             memByteMask,
   output logic                   memWriteEnable,
   input  logic [31:0]            memReadData,
   output logic                   stallCore,
   output logic                   coreResetRequest,
   output logic                   halted
);

   localparam int CW = $clog2(max_int(DRAIN_CYCLES, RESET_PULSE_CYCLES)) + 1;

   arbState_t     state_q, state_d;
   logic          rvalid_q, rvalid_d;
   logic          in_ldr, cnt_load, cnt_dec, cnt_zero;
   logic [CW-1:0] cnt_load_val;

   assign in_ldr = (state_q == ARB_LOADER);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_CORE:   state_d = ldrValid ? ARB_DRAIN : ARB_CORE;
         ARB_DRAIN:  state_d = cnt_zero ? ARB_LOADER : ARB_DRAIN;
         ARB_LOADER: state_d = ldrRelease ? (ldrResetCore ? ARB_RESUME : ARB_CORE) : ARB_LOADER;
         ARB_RESUME: state_d = cnt_zero ? ARB_CORE : ARB_RESUME;
         default:    state_d = ARB_CORE;
      endcase
      cnt_load     = (state_q == ARB_CORE && ldrValid) || (in_ldr && ldrRelease && ldrResetCore);
      cnt_load_val = (state_q == ARB_CORE) ? CW'(DRAIN_CYCLES - 1) : CW'(RESET_PULSE_CYCLES - 1);
      cnt_dec      = (state_q == ARB_DRAIN) || (state_q == ARB_RESUME);
      rvalid_d     = in_ldr && ldrValid && !ldrWrite;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ARB_CORE;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rvalid_q <= rvalid_d;
      end
   end

   jzjpcc_down_counter #(.W(CW)) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Core stores are simply masked off while the loader owns the port.
   always_comb begin
      memAddr        = in_ldr ? ldrAddr : coreAddr;
      memWriteData   = in_ldr ? ldrWriteData : coreWriteData;
      memByteMask    = in_ldr ? 4'hF : coreByteMask;
      memWriteEnable = in_ldr ? (ldrValid && ldrWrite) : coreWriteEnable;
   end

   assign ldrReady         = in_ldr;
   assign halted           = in_ldr;
   assign stallCore        = (state_q != ARB_CORE);
   assign coreResetRequest = (state_q == ARB_RESUME);
   assign ldrReadValid     = rvalid_q;
   assign ldrReadData      = rvalid_q ? memReadData : 32'h0;

endmodule

// File: tb/tb_jzjpcc_mem_arbiter.sv
// tb_jzjpcc_mem_arbiter: directed vector table, hand sequences and random traffic
// against a phase/timeline reference model with a shadow copy of RAM.
module tb_jzjpcc_mem_arbiter;

   localparam int AW = 12;
   localparam int DC = 4;
   localparam int RC = 2;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
   localparam int M_CORE = 0, M_DRAIN = 1, M_LOADER = 2, M_RESUME = 3;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] coreAddr, ldrAddr, memAddr;
   logic [31:0]   coreWriteData, ldrWriteData, ldrReadData, memWriteData, memReadData;
   logic [3:0]    coreByteMask, memByteMask;
   logic          coreWriteEnable, ldrValid, ldrReady, ldrWrite, ldrReadValid;
   logic          ldrRelease, ldrResetCore, memWriteEnable, stallCore, coreResetRequest, halted;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   jzjpcc_mem_arbiter #(.RAM_A_WIDTH(AW), .DRAIN_CYCLES(DC), .RESET_PULSE_CYCLES(RC)) dut (
      .clock(clock), .reset(reset),
      .coreAddr(coreAddr), .coreWriteData(coreWriteData), .coreByteMask(coreByteMask),
      .coreWriteEnable(coreWriteEnable),
      .ldrValid(ldrValid), .ldrReady(ldrReady), .ldrWrite(ldrWrite), .ldrAddr(ldrAddr),
      .ldrWriteData(ldrWriteData), .ldrReadData(ldrReadData), .ldrReadValid(ldrReadValid),
      .ldrRelease(ldrRelease), .ldrResetCore(ldrResetCore),
      .memAddr(memAddr), .memWriteData(memWriteData), .memByteMask(memByteMask),
      .memWriteEnable(memWriteEnable), .memReadData(memReadData),
      .stallCore(stallCore), .coreResetRequest(coreResetRequest), .halted(halted)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Backend data port: byte-masked writes, one-cycle registered read.
   logic [31:0] mem [0:(1<<AW)-1] = '{default: 32'h0};
   logic [31:0] rd_q = 32'h0;
   always @(posedge clock) begin
      rd_q <= mem[memAddr];
      if (memWriteEnable) mem[memAddr] <= merge(mem[memAddr], memWriteData, memByteMask);
   end
   assign memReadData = rd_q;

   // Reference model: phase plus cycles left in it, and a shadow of RAM contents.
   int          m_mode, m_left;
   logic        m_rv;
   logic [31:0] m_rd;
   logic [31:0] shadow [0:(1<<AW)-1] = '{default: 32'h0};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_CORE;
      m_left = 0;
      m_rv   = 1'b0;
      m_rd   = 32'h0;
   endtask

   task automatic model_check();
      logic lo;
      lo = (m_mode == M_LOADER);
      chk("stallCore", 32'(stallCore), 32'(m_mode != M_CORE));
      chk("ldrReady", 32'(ldrReady), 32'(lo));
      chk("halted", 32'(halted), 32'(lo));
      chk("coreResetRequest", 32'(coreResetRequest), 32'(m_mode == M_RESUME));
      chk("memAddr", 32'(memAddr), 32'(lo ? ldrAddr : coreAddr));
      chk("memWriteData", memWriteData, lo ? ldrWriteData : coreWriteData);
      chk("memByteMask", 32'(memByteMask), 32'(lo ? 4'hF : coreByteMask));
      chk("memWriteEnable", 32'(memWriteEnable), 32'(lo ? (ldrValid & ldrWrite) : coreWriteEnable));
      chk("ldrReadValid", 32'(ldrReadValid), 32'(m_rv));
      chk("ldrReadData", ldrReadData, m_rv ? m_rd : 32'h0);
   endtask

   task automatic model_update();
      logic lo;
      lo = (m_mode == M_LOADER);
      m_rv = lo && ldrValid && !ldrWrite;
      m_rd = shadow[ldrAddr];
      if (lo && ldrValid && ldrWrite) shadow[ldrAddr] = ldrWriteData;
      if (!lo && coreWriteEnable) shadow[coreAddr] = merge(shadow[coreAddr], coreWriteData, coreByteMask);
      if (!reset) model_reset();
      else if (m_mode == M_CORE) begin
         if (ldrValid) begin m_mode = M_DRAIN; m_left = DC; end
      end else if (m_mode == M_DRAIN) begin
         m_left--;
         if (m_left == 0) m_mode = M_LOADER;
      end else if (m_mode == M_LOADER) begin
         if (ldrRelease) begin
            m_mode = ldrResetCore ? M_RESUME : M_CORE;
            m_left = RC;
         end
      end else begin
         m_left--;
         if (m_left == 0) m_mode = M_CORE;
      end
   endtask

   task automatic settle();
      @(negedge clock);
      model_check();
   endtask

   task automatic advance();
      @(posedge clock);
      model_update();
      #1;
   endtask

   task automatic set_ldr(input logic v, input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic rel, input logic rc);
      ldrValid = v; ldrWrite = w; ldrAddr = a; ldrWriteData = d; ldrRelease = rel; ldrResetCore = rc;
   endtask

   task automatic set_core(input logic we, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
      coreWriteEnable = we; coreAddr = a; coreWriteData = d; coreByteMask = m;
   endtask

   typedef struct {
      logic          lv, lw;
      logic [AW-1:0] la;
      logic [31:0]   ld;
      logic          rel, rc;
      logic          e_stall, e_ready, e_rv, e_crr;
      logic [31:0]   e_rd;
   } vec_t;

   vec_t tbl [13];

   initial begin
      tbl[0]  = '{H, H, 12'h010, 32'hDEADBEEF, L, L, L, L, L, L, 32'h0};
      tbl[1]  = '{H, H, 12'h010, 32'hDEADBEEF, L, L, H, L, L, L, 32'h0};
      tbl[2]  = '{H, H, 12'h010, 32'hDEADBEEF, L, L, H, L, L, L, 32'h0};
      tbl[3]  = '{H, H, 12'h010, 32'hDEADBEEF, L, L, H, L, L, L, 32'h0};
      tbl[4]  = '{H, H, 12'h010, 32'hDEADBEEF, L, L, H, L, L, L, 32'h0};
      tbl[5]  = '{H, H, 12'h010, 32'hDEADBEEF, L, L, H, H, L, L, 32'h0};
      tbl[6]  = '{H, L, 12'h010, 32'h0,        L, L, H, H, L, L, 32'h0};
      tbl[7]  = '{L, L, 12'h010, 32'h0,        L, L, H, H, H, L, 32'hDEADBEEF};
      tbl[8]  = '{H, L, 12'h010, 32'h0,        H, H, H, H, L, L, 32'h0};
      tbl[9]  = '{L, L, 12'h010, 32'h0,        L, L, H, L, H, H, 32'hDEADBEEF};
      tbl[10] = '{L, L, 12'h010, 32'h0,        L, L, H, L, L, H, 32'h0};
      tbl[11] = '{L, L, 12'h010, 32'h0,        L, L, L, L, L, L, 32'h0};
      tbl[12] = '{L, L, 12'h010, 32'h0,        L, L, L, L, L, L, 32'h0};

      reset = 1'b0;
      set_ldr(L, L, '0, '0, L, L);
      set_core(L, '0, '0, '0);
      model_reset();
      settle();
      advance();
      reset = 1'b1;
      settle();
      advance();

      // Directed table: request, drain, write/read, release with core reset.
      set_core(L, 12'h100, 32'h0, 4'h0);
      for (int i = 0; i < 13; i++) begin
         set_ldr(tbl[i].lv, tbl[i].lw, tbl[i].la, tbl[i].ld, tbl[i].rel, tbl[i].rc);
         settle();
         chk($sformatf("tbl%0d stallCore", i), 32'(stallCore), 32'(tbl[i].e_stall));
         chk($sformatf("tbl%0d ldrReady", i), 32'(ldrReady), 32'(tbl[i].e_ready));
         chk($sformatf("tbl%0d ldrReadValid", i), 32'(ldrReadValid), 32'(tbl[i].e_rv));
         chk($sformatf("tbl%0d coreResetRequest", i), 32'(coreResetRequest), 32'(tbl[i].e_crr));
         chk($sformatf("tbl%0d ldrReadData", i), ldrReadData, tbl[i].e_rd);
         if (i == 5) chk("tbl5 memByteMask", 32'(memByteMask), 32'hF);
         advance();
      end

      // Release ignored in CORE and DRAIN; core store in DRAIN passes, in LOADER dropped.
      set_ldr(L, L, '0, '0, H, H);
      settle(); advance();
      set_ldr(H, L, '0, '0, L, L);
      settle();
      chk("rel_in_core stallCore", 32'(stallCore), 32'h0);
      advance();
      set_ldr(L, L, '0, '0, H, H);
      set_core(H, 12'h020, 32'h12345678, 4'b0011);
      settle();
      chk("drain store memWriteEnable", 32'(memWriteEnable), 32'h1);
      chk("drain store memByteMask", 32'(memByteMask), 32'h3);
      chk("drain store memAddr", 32'(memAddr), 32'h020);
      advance();
      set_ldr(L, L, '0, '0, L, L);
      set_core(L, 12'h020, 32'h12345678, 4'b0011);
      repeat (3) begin settle(); advance(); end
      set_core(H, 12'h020, 32'hAAAAAAAA, 4'b1111);
      settle();
      chk("drain done ldrReady", 32'(ldrReady), 32'h1);
      chk("loader drops core store", 32'(memWriteEnable), 32'h0);
      advance();
      set_core(L, 12'h020, 32'h0, 4'h0);
      set_ldr(H, L, 12'h020, '0, L, L);
      settle(); advance();
      set_ldr(L, L, '0, '0, H, L);
      settle();
      chk("masked store readback valid", 32'(ldrReadValid), 32'h1);
      chk("masked store readback data", ldrReadData, 32'h00005678);
      advance();
      set_ldr(L, L, '0, '0, L, L);
      settle();
      chk("plain release stallCore", 32'(stallCore), 32'h0);
      chk("plain release coreResetRequest", 32'(coreResetRequest), 32'h0);
      advance();

      // Asynchronous reset while the loader owns the port.
      set_ldr(H, H, 12'h030, 32'h0BADF00D, L, L);
      settle(); advance();
      set_ldr(L, L, '0, '0, L, L);
      repeat (DC) begin settle(); advance(); end
      set_ldr(H, H, 12'h030, 32'h0BADF00D, L, L);
      settle();
      chk("pre-reset halted", 32'(halted), 32'h1);
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      chk("async reset stallCore", 32'(stallCore), 32'h0);
      chk("async reset halted", 32'(halted), 32'h0);
      chk("async reset ldrReady", 32'(ldrReady), 32'h0);
      advance();
      settle(); advance();
      reset = 1'b1;
      set_ldr(L, L, '0, '0, L, L);
      settle(); advance();

      // Random traffic over a small address window so reads hit earlier writes.
      for (int n = 0; n < 600; n++) begin
         set_ldr(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)),
                 $urandom, ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1);
         set_core(($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), $urandom, 4'($urandom));
         settle();
         advance();
      end
      set_ldr(L, L, '0, '0, L, L);
      set_core(L, '0, '0, '0);
      settle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
